esp32_boot_sequencer: RTL and testbench
=======================================

ESP32_BOOT_SEQUENCER -- requirements
Module: esp32_boot_sequencer

Interface
REQ-001 SHALL have parameter C_sync_stages, default 2, meaning the synchronizer depth for ftdi_ndtr/ftdi_nrts (legal range 2..4).
REQ-002 SHALL have parameter C_en_low_cycles, default 2500, meaning the minimum clocks wifi_en is held low per reset (100 us at 25 MHz).
REQ-003 SHALL have parameter C_strap_cycles, default 131072, meaning the clocks GPIO0/strap are held after EN release.
REQ-004 SHALL have port clk_25mhz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ftdi_ndtr, input, 1 bit: asynchronous USB-serial DTR line.
REQ-007 SHALL have port ftdi_nrts, input, 1 bit: asynchronous USB-serial RTS line.
REQ-008 SHALL have port btn0_n, input, 1 bit: active-low manual boot button, already debounced.
REQ-009 SHALL have port wifi_en, output, 1 bit: ESP32 enable, active high.
REQ-010 SHALL have port wifi_gpio0, output, 1 bit: ESP32 boot strap, where 0 selects the download mode.
REQ-011 SHALL have port strap_oe, output, 1 bit: when high, the top level drives sd_d[0]=0 (GPIO2 strap); when low, sd_d[0] is released.
REQ-012 SHALL have port prog_active, output, 1 bit: high while in RESET or STRAP.
REQ-013 SHALL have port prog_count, output, 8 bits: count of completed download-mode entries.
REQ-014 SHALL have port state_dbg, output, 2 bits: the current FSM encoding.

Function
REQ-015 SHALL synchronize ndtr and nrts through C_sync_stages flops each; decoded value d = {sync_ndtr, sync_nrts}.
REQ-016 SHALL decode d as follows: 2'b10 is REQ_RST, 2'b01 is REQ_BOOT, and 2'b00 or 2'b11 is NONE.
REQ-017 SHALL implement the FSM states IDLE=2'b00, RESET=2'b01 and STRAP=2'b10; 2'b11 is illegal and SHALL go to IDLE on the next clock.
REQ-018 SHALL, in IDLE, drive wifi_en=1, wifi_gpio0=btn0_n (registered) and strap_oe=0; on REQ_RST it SHALL go to RESET and clear the counter.
REQ-019 SHALL, in RESET, drive wifi_en=0, wifi_gpio0=1 and strap_oe=0, with the counter incrementing each clock.
REQ-020 SHALL leave RESET only when counter >= C_en_low_cycles-1 and d != REQ_RST, as follows: if d == REQ_BOOT, go to STRAP and clear the counter; otherwise go to IDLE.
REQ-021 SHALL, in STRAP, drive wifi_en=1, wifi_gpio0=0 and strap_oe=1, with the counter incrementing.
REQ-022 SHALL leave STRAP for IDLE when counter == C_strap_cycles-1, and SHALL increment prog_count by 1 on that transition (8-bit wrap: 255 -> 0).
REQ-023 SHALL, on REQ_RST while in STRAP, go to RESET with the counter cleared and no prog_count increment; this takes priority over the STRAP timeout in the same cycle.
REQ-024 SHALL ignore REQ_BOOT in IDLE (no EN pulse means no strap).
REQ-025 SHALL use a 20-bit counter that saturates and never wraps, including while a request holds RESET beyond its minimum.
REQ-026 SHALL register all outputs; the output change SHALL appear 1 clock after the state transition, so the latency from the pin edge to wifi_en is C_sync_stages+2 clocks.
REQ-027 SHALL ensure wifi_en and wifi_gpio0 are never simultaneously 0.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, counter=0, prog_count=0, wifi_en=1, wifi_gpio0=1, strap_oe=0, prog_active=0, and synchronizer flops=1.
REQ-029 SHALL, on rst asserted mid-RESET or mid-STRAP, abort the sequence with no prog_count increment, and release the strap the following clock.
REQ-030 SHALL restart normal decoding on the first clock after rst deasserts.

Verification (bench: C_en_low_cycles=4, C_strap_cycles=16, C_sync_stages=2)
REQ-031 SHALL verify the esptool sequence: d=10 for 10 clocks, then 01 for 30 clocks, then 11 -> wifi_en low for 10+ clocks, then gpio0=0 and strap_oe=1 for exactly 16 clocks, then prog_count=1 and state_dbg=00.
REQ-032 SHALL verify a short pulse: d=10 for 1 clock, then 11 -> wifi_en low for exactly 4 clocks, gpio0 stays 1, and prog_count is unchanged.
REQ-033 SHALL verify that d=01 applied in IDLE for 50 clocks leaves wifi_en=1, gpio0=btn0_n and strap_oe=0 throughout.
REQ-034 SHALL verify re-reset: d=10 at STRAP clock 8 -> return to RESET, wifi_en=0 for 4+ clocks, and prog_count is unchanged.
REQ-035 SHALL verify rst=1 for 1 clock at STRAP clock 5 -> next clock state_dbg=00, strap_oe=0 and wifi_gpio0=1; and 256 complete sequences -> prog_count wraps to 0.
REQ-036 SHALL verify btn0_n=0 in IDLE -> wifi_gpio0=0 one clock later, and wifi_en stays 1.

Source files
------------

// File: rtl/esp32_boot_sequencer.sv
// Purpose : drives the ESP32 EN / GPIO0 / GPIO2 straps from USB-serial DTR/RTS (esptool auto-reset) and a boot button.
// Latency : pin edge to wifi_en is C_sync_stages+2 clocks (synchronizer, state register, output register).
// Backpressure: none; the sequencer free-runs and requests are level-sampled every clock.
//
// Ports:
//   clk_25mhz   - single clock, all logic on the rising edge
//   rst         - synchronous active-high reset
//   ftdi_ndtr   - asynchronous DTR line from the USB-serial bridge
//   ftdi_nrts   - asynchronous RTS line from the USB-serial bridge
//   btn0_n      - debounced active-low manual boot button, passed to GPIO0 while idle
//   wifi_en     - ESP32 enable, active high
//   wifi_gpio0  - ESP32 GPIO0 strap, 0 selects download mode
//   strap_oe    - high while the top level must drive GPIO2 (sd_d[0]) low
//   prog_active - high while a reset/strap sequence is in progress
//   prog_count  - number of completed download-mode entries, wraps at 8 bits
//   state_dbg   - FSM encoding, registered alongside the other outputs

module esp32_boot_sequencer #(
  parameter int C_sync_stages   = 2,
  parameter int C_en_low_cycles = 2500,
  parameter int C_strap_cycles  = 131072
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn0_n,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic       strap_oe,
  output logic       prog_active,
  output logic [7:0] prog_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RESET   = 2'b01,
    STRAP   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [19:0] EN_LOW_LAST = 20'(C_en_low_cycles - 1);
  localparam logic [19:0] STRAP_LAST  = 20'(C_strap_cycles - 1);
  localparam logic [19:0] CNT_MAX     = 20'hF_FFFF;

  // Synchronizers idle high so a reset never looks like a request.
  logic [C_sync_stages-1:0] ndtr_sync;
  logic [C_sync_stages-1:0] nrts_sync;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      ndtr_sync <= '1;
      nrts_sync <= '1;
    end else begin
      ndtr_sync <= {ndtr_sync[C_sync_stages-2:0], ftdi_ndtr};
      nrts_sync <= {nrts_sync[C_sync_stages-2:0], ftdi_nrts};
    end
  end

  logic [1:0] d;
  logic       req_rst;
  logic       req_boot;

  assign d        = {ndtr_sync[C_sync_stages-1], nrts_sync[C_sync_stages-1]};
  assign req_rst  = (d == 2'b10);
  assign req_boot = (d == 2'b01);

  state_t      state;
  logic [19:0] cnt;
  logic [19:0] cnt_inc;

  // Saturating increment: a long-held reset request must not wrap the
  // counter back below the EN-low minimum.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 20'd1;

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prog_count  <= '0;
      wifi_en     <= 1'b1;
      wifi_gpio0  <= 1'b1;
      strap_oe    <= 1'b0;
      prog_active <= 1'b0;
      state_dbg   <= IDLE;
    end else begin
      // Outputs follow the state one clock later. Each state drives EN and
      // GPIO0 together from one decode, so they can never both be low.
      state_dbg <= state;
      case (state)
        RESET: begin
          wifi_en     <= 1'b0;
          wifi_gpio0  <= 1'b1;
          strap_oe    <= 1'b0;
          prog_active <= 1'b1;
        end
        STRAP: begin
          wifi_en     <= 1'b1;
          wifi_gpio0  <= 1'b0;
          strap_oe    <= 1'b1;
          prog_active <= 1'b1;
        end
        default: begin
          wifi_en     <= 1'b1;
          wifi_gpio0  <= btn0_n;
          strap_oe    <= 1'b0;
          prog_active <= 1'b0;
        end
      endcase

      case (state)
        IDLE: begin
          // REQ_BOOT alone is ignored: without an EN pulse the strap is useless.
          if (req_rst) begin
            state <= RESET;
            cnt   <= '0;
          end
        end
        RESET: begin
          cnt <= cnt_inc;
          if ((cnt >= EN_LOW_LAST) && !req_rst) begin
            if (req_boot) begin
              state <= STRAP;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        STRAP: begin
          // A fresh reset request wins over the strap timeout.
          if (req_rst) begin
            state <= RESET;
            cnt   <= '0;
          end else if (cnt == STRAP_LAST) begin
            state      <= IDLE;
            prog_count <= prog_count + 8'd1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Purpose : self-checking bench for esp32_boot_sequencer with a reference model of the boot sequence.
// Latency : model tracks the pin-to-decision delay with a queue and compares every output every clock.
// Backpressure: not applicable.

module tb_esp32_boot_sequencer;

  localparam int SYNC   = 2;
  localparam int ENLOW  = 4;
  localparam int STRAPC = 16;

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic       ftdi_ndtr;
  logic       ftdi_nrts;
  logic       btn0_n;
  logic       wifi_en;
  logic       wifi_gpio0;
  logic       strap_oe;
  logic       prog_active;
  logic [7:0] prog_count;
  logic [1:0] state_dbg;

  always #20 clk_25mhz = ~clk_25mhz;

  esp32_boot_sequencer #(
    .C_sync_stages  (SYNC),
    .C_en_low_cycles(ENLOW),
    .C_strap_cycles (STRAPC)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .ftdi_ndtr  (ftdi_ndtr),
    .ftdi_nrts  (ftdi_nrts),
    .btn0_n     (btn0_n),
    .wifi_en    (wifi_en),
    .wifi_gpio0 (wifi_gpio0),
    .strap_oe   (strap_oe),
    .prog_active(prog_active),
    .prog_count (prog_count),
    .state_dbg  (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = EN high and waiting, 1 = EN held low,
  // 2 = download strap applied. Pin values travel through a delay queue.
  int         m_phase;
  int         m_held;
  int         m_strap_left;
  int         m_pc;
  logic [1:0] m_pipe[$];
  logic       m_en;
  logic       m_g;
  logic       m_oe;
  logic       m_pa;
  logic [1:0] m_sd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [1:0] dv;
    int         old;
    if (rst) begin
      m_pipe = {};
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(2'b11);
      m_phase = 0; m_held = 0; m_strap_left = 0; m_pc = 0;
      m_en = 1'b1; m_g = 1'b1; m_oe = 1'b0; m_pa = 1'b0; m_sd = 2'b00;
    end else begin
      old = m_phase;
      dv  = m_pipe.pop_front();
      m_pipe.push_back({ftdi_ndtr, ftdi_nrts});
      m_en = (old != 1);
      m_g  = (old == 1) ? 1'b1 : ((old == 2) ? 1'b0 : btn0_n);
      m_oe = (old == 2);
      m_pa = (old != 0);
      m_sd = 2'(old);
      if (old == 0) begin
        if (dv == 2'b10) begin m_phase = 1; m_held = 0; end
      end else if (old == 1) begin
        m_held++;
        if (m_held >= ENLOW && dv != 2'b10) begin
          if (dv == 2'b01) begin m_phase = 2; m_strap_left = STRAPC; end
          else m_phase = 0;
        end
      end else begin
        if (dv == 2'b10) begin
          m_phase = 1; m_held = 0;
        end else begin
          m_strap_left--;
          if (m_strap_left == 0) begin
            m_phase = 0;
            m_pc = (m_pc + 1) % 256;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    model_edge();
    #1;
    chk("wifi_en",     wifi_en,     m_en);
    chk("wifi_gpio0",  wifi_gpio0,  m_g);
    chk("strap_oe",    strap_oe,    m_oe);
    chk("prog_active", prog_active, m_pa);
    chk("prog_count",  prog_count,  m_pc);
    chk("state_dbg",   state_dbg,   m_sd);
    chk("en_gpio0_not_both_low", wifi_en | wifi_gpio0, 1);
  endtask

  task automatic set_d(input logic [1:0] v);
    {ftdi_ndtr, ftdi_nrts} = v;
  endtask

  task automatic wait_strap(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (strap_oe) begin found = 1; break; end
      tick();
    end
    chk(tag, found, 1);
  endtask

  int n, low, g0, strap, bad;

  initial begin
    rst = 1'b1; btn0_n = 1'b1; set_d(2'b11);
    tick(); tick();
    chk("rst_state_dbg", state_dbg, 0);
    chk("rst_wifi_en", wifi_en, 1);
    chk("rst_gpio0", wifi_gpio0, 1);
    chk("rst_strap_oe", strap_oe, 0);
    chk("rst_prog_active", prog_active, 0);
    chk("rst_prog_count", prog_count, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Manual boot button in idle.
    btn0_n = 1'b0; tick();
    chk("btn_gpio0_low", wifi_gpio0, 0);
    chk("btn_en_high", wifi_en, 1);
    btn0_n = 1'b1; tick();

    // Pin edge to wifi_en latency.
    set_d(2'b10); n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (!wifi_en) break;
    end
    chk("en_latency", n, SYNC + 2);
    set_d(2'b11);
    repeat (20) tick();

    // Short reset pulse: EN low for exactly the minimum, no strap.
    set_d(2'b10); tick(); set_d(2'b11);
    low = 0; g0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!wifi_en) low++;
      if (!wifi_gpio0) g0++;
    end
    chk("short_en_low", low, ENLOW);
    chk("short_gpio0_low", g0, 0);
    chk("short_prog_count", prog_count, 0);

    // esptool sequence.
    low = 0; strap = 0;
    set_d(2'b10);
    for (int i = 0; i < 10; i++) begin tick(); if (!wifi_en) low++; end
    set_d(2'b01);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!wifi_en) low++;
      if (strap_oe && !wifi_gpio0) strap++;
    end
    set_d(2'b11);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!wifi_en) low++;
      if (strap_oe && !wifi_gpio0) strap++;
    end
    chk("esp_en_low_ge10", (low >= 10), 1);
    chk("esp_strap_cycles", strap, STRAPC);
    chk("esp_prog_count", prog_count, 1);
    chk("esp_state_idle", state_dbg, 0);

    // Boot request alone in idle does nothing.
    set_d(2'b01); bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!wifi_en || strap_oe || (wifi_gpio0 !== btn0_n)) bad++;
    end
    chk("boot_in_idle_ignored", bad, 0);
    set_d(2'b11); repeat (5) tick();

    // Re-reset in the middle of the strap.
    set_d(2'b10); tick(); set_d(2'b01);
    wait_strap("rereset_wait_strap");
    repeat (7) tick();
    set_d(2'b10); tick(); tick(); set_d(2'b11);
    low = 0; strap = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!wifi_en) low++;
      if (strap_oe) strap++;
    end
    chk("rereset_en_low_ge4", (low >= ENLOW), 1);
    chk("rereset_prog_count", prog_count, 1);
    chk("rereset_state_idle", state_dbg, 0);

    // rst during the strap aborts it immediately.
    set_d(2'b10); tick(); set_d(2'b01);
    wait_strap("rst_abort_wait_strap");
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0; set_d(2'b11);
    chk("abort_state_dbg", state_dbg, 0);
    chk("abort_strap_oe", strap_oe, 0);
    chk("abort_gpio0", wifi_gpio0, 1);
    chk("abort_prog_count", prog_count, 0);
    repeat (5) tick();

    // 256 complete download entries wrap the counter.
    for (int s = 0; s < 256; s++) begin
      set_d(2'b10); repeat ($urandom_range(1, 3)) tick();
      set_d(2'b01); repeat ($urandom_range(6, 10)) tick();
      set_d($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00);
      repeat ($urandom_range(18, 25)) tick();
      if (s == 0) chk("wrap_first", prog_count, 1);
      if (s == 254) chk("wrap_255", prog_count, 255);
    end
    chk("wrap_to_zero", prog_count, 0);

    // Random pin activity, button presses and occasional resets.
    for (int r = 0; r < 120; r++) begin
      set_d(2'($urandom_range(0, 3)));
      btn0_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
